// File: rtl/n64_pkg.sv
// Shared joybus definitions: commands, status reply, FSM states, bit timing.
// Status reply enabled by defining N64_RESP_STATUS_EN.
package n64_pkg;

  localparam logic [7:0]  CMD_INFO    = 8'h00;
  localparam logic [7:0]  CMD_POLL    = 8'h01;
  localparam logic [7:0]  CMD_RESET   = 8'hFF;
  localparam logic [23:0] STATUS_WORD = 24'h050002;

  localparam int unsigned US_1 = 1;
  localparam int unsigned US_2 = 2;
  localparam int unsigned US_3 = 3;

  localparam int TW = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RX_LOW,
    ST_RX_HIGH,
    ST_RX_STOP,
    ST_TURN,
    ST_TX_LOW,
    ST_TX_HIGH,
    ST_TX_STOP,
    ST_WAIT_IDLE
  } state_t;

  // Timer load value giving a phase of exactly cyc clocks: one cycle
  // for the registered load and one for the transition on done.
  function automatic logic [TW-1:0] ticks(input int unsigned cyc);
    return TW'(cyc - 32'd2);
  endfunction

endpackage

// File: rtl/n64_controller_responder_if.sv
// Register-side bundle of the joybus responder: button word in,
// command/response status out.
interface n64_controller_responder_if;
  import n64_pkg::*;

  logic [31:0] button_data;
  logic        tx_active;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic        resp_done;
  logic        rx_error;

  modport master (
    output button_data,
    input  tx_active, cmd_valid, cmd_byte,
    input  resp_done, rx_error
  );

  modport slave (
    input  button_data,
    output tx_active, cmd_valid, cmd_byte,
    output resp_done, rx_error
  );

endinterface

// File: rtl/n64_pulse_timer.sv
// Loadable down-counter shared by RX timeout, turnaround and TX phases.
// done is suppressed while a load is pending so a stale zero never fires.
module n64_pulse_timer
  import n64_pkg::*;
#(
  parameter int W = TW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic [W-1:0] count,
  output logic         done
);

  // Load wins, otherwise count down and park at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (load)
      count <= value;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign done = (count == '0) && !load;

endmodule

// File: rtl/n64_controller_responder.sv
// Device-side joybus responder: decodes a command byte on fab_pin and
// answers polls (and info/reset when N64_RESP_STATUS_EN is defined).
module n64_controller_responder
  import n64_pkg::*;
#(
  parameter int unsigned CYCLES_PER_US = 100,
  parameter int unsigned TURNAROUND_US = 2,
  parameter int unsigned TIMEOUT_US    = 5
) (
  input  logic PCLK,
  input  logic PRESERN,
  inout  wire  fab_pin,
  n64_controller_responder_if.slave bus
);

  localparam int unsigned US = CYCLES_PER_US;
  localparam logic [TW-1:0] TO_V = ticks(TIMEOUT_US * US);
  localparam logic [TW-1:0] TA_V = ticks(TURNAROUND_US * US);
  localparam logic [TW-1:0] T1_V = ticks(US_1 * US);
  localparam logic [TW-1:0] T2_V = ticks(US_2 * US);
  localparam logic [TW-1:0] T3_V = ticks(US_3 * US);
  localparam logic [TW-1:0] B1_MIN = TO_V - TW'(US_2 * US);

  state_t          state;
  logic [1:0]      sync_q;
  logic            line_q;
  logic            line;
  logic            fall;
  logic            rise;
  logic            drive_low;
  logic            t_load;
  logic [TW-1:0]   t_val;
  logic [TW-1:0]   t_cnt;
  logic            t_done;
  logic [3:0]      rx_cnt;
  logic [7:0]      rx_byte;
  logic [31:0]     tx_sh;
  logic [5:0]      tx_cnt;
  logic [5:0]      tx_len;

  assign fab_pin = drive_low ? 1'b0 : 1'bz;

  assign line = sync_q[1];
  assign fall = line_q & ~line;
  assign rise = ~line_q & line;

  n64_pulse_timer #(.W(TW)) u_timer (
    .clk   (PCLK),
    .rst_n (PRESERN),
    .load  (t_load),
    .value (t_val),
    .count (t_cnt),
    .done  (t_done)
  );

  // Two-flop synchronizer plus history bit for edge detection
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      sync_q <= 2'b11;
      line_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], fab_pin};
      line_q <= sync_q[1];
    end
  end

  // Protocol FSM with registered line drive and status pulses
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state         <= ST_IDLE;
      drive_low     <= 1'b0;
      t_load        <= 1'b0;
      t_val         <= '0;
      rx_cnt        <= '0;
      rx_byte       <= '0;
      tx_sh         <= '0;
      tx_cnt        <= '0;
      tx_len        <= '0;
      bus.tx_active <= 1'b0;
      bus.cmd_valid <= 1'b0;
      bus.cmd_byte  <= '0;
      bus.resp_done <= 1'b0;
      bus.rx_error  <= 1'b0;
    end else begin
      t_load        <= 1'b0;
      bus.cmd_valid <= 1'b0;
      bus.resp_done <= 1'b0;
      bus.rx_error  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (fall) begin
            state   <= ST_RX_LOW;
            rx_cnt  <= '0;
            t_load  <= 1'b1;
            t_val   <= TO_V;
          end
        end
        ST_RX_LOW: begin
          if (rise) begin
            rx_byte <= {rx_byte[6:0], t_cnt > B1_MIN};
            rx_cnt  <= rx_cnt + 4'd1;
            state   <= ST_RX_HIGH;
            t_load  <= 1'b1;
            t_val   <= TO_V;
          end else if (t_done) begin
            bus.rx_error <= 1'b1;
            state        <= ST_WAIT_IDLE;
            t_load       <= 1'b1;
            t_val        <= TO_V;
          end
        end
        ST_RX_HIGH: begin
          if (fall) begin
            state  <= (rx_cnt == 4'd8) ? ST_RX_STOP : ST_RX_LOW;
            t_load <= 1'b1;
            t_val  <= TO_V;
          end else if (t_done) begin
            state <= ST_IDLE;
          end
        end
        ST_RX_STOP: begin
          if (rise) begin
            bus.cmd_valid <= 1'b1;
            bus.cmd_byte  <= rx_byte;
            tx_cnt        <= '0;
            unique case (1'b1)
              (rx_byte == CMD_POLL): begin
                tx_sh         <= bus.button_data;
                tx_len        <= 6'd32;
                state         <= ST_TURN;
                bus.tx_active <= 1'b1;
                t_load        <= 1'b1;
                t_val         <= TA_V;
              end
`ifdef N64_RESP_STATUS_EN
              (rx_byte == CMD_INFO),
              (rx_byte == CMD_RESET): begin
                tx_sh         <= {STATUS_WORD, 8'h00};
                tx_len        <= 6'd24;
                state         <= ST_TURN;
                bus.tx_active <= 1'b1;
                t_load        <= 1'b1;
                t_val         <= TA_V;
              end
`endif
              default: state <= ST_IDLE;
            endcase
          end else if (t_done) begin
            bus.rx_error <= 1'b1;
            state        <= ST_WAIT_IDLE;
            t_load       <= 1'b1;
            t_val        <= TO_V;
          end
        end
        ST_TURN: begin
          if (t_done) begin
            state     <= ST_TX_LOW;
            drive_low <= 1'b1;
            t_load    <= 1'b1;
            t_val     <= tx_sh[31] ? T1_V : T3_V;
          end
        end
        ST_TX_LOW: begin
          if (t_done) begin
            state     <= ST_TX_HIGH;
            drive_low <= 1'b0;
            t_load    <= 1'b1;
            t_val     <= tx_sh[31] ? T3_V : T1_V;
          end
        end
        ST_TX_HIGH: begin
          if (t_done) begin
            drive_low <= 1'b1;
            t_load    <= 1'b1;
            if (tx_cnt == tx_len - 6'd1) begin
              state <= ST_TX_STOP;
              t_val <= T2_V;
            end else begin
              tx_cnt <= tx_cnt + 6'd1;
              tx_sh  <= {tx_sh[30:0], 1'b0};
              state  <= ST_TX_LOW;
              t_val  <= tx_sh[30] ? T1_V : T3_V;
            end
          end
        end
        ST_TX_STOP: begin
          if (t_done) begin
            drive_low     <= 1'b0;
            bus.resp_done <= 1'b1;
            bus.tx_active <= 1'b0;
            state         <= ST_WAIT_IDLE;
            t_load        <= 1'b1;
            t_val         <= TO_V;
          end
        end
        ST_WAIT_IDLE: begin
          if (!line) begin
            t_load <= 1'b1;
            t_val  <= TO_V;
          end else if (t_done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_n64_controller_responder.sv
// Scoreboard bench for n64_controller_responder: a console model drives
// frames, a monitor decodes the reply and checks it against a queue.
module tb_n64_controller_responder;

  localparam int EV_CMD  = 0;
  localparam int EV_ERR  = 1;
  localparam int EV_TURN = 2;
  localparam int EV_LOW  = 3;
  localparam int EV_HIGH = 4;
  localparam int EV_DONE = 5;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  logic PCLK;
  logic PRESERN;
  logic con_low;
  wire  fab_pin;

  ev_t  exp_q[$];
  int   checks;
  int   failures;

  string kname [6] = '{"cmd", "err", "turn", "low", "high", "done"};

  n64_controller_responder_if bus ();

  pullup (fab_pin);
  assign fab_pin = con_low ? 1'b0 : 1'bz;

  n64_controller_responder dut (
    .PCLK    (PCLK),
    .PRESERN (PRESERN),
    .fab_pin (fab_pin),
    .bus     (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic push(input int k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  // Expected reply: turnaround, then low/high per bit, then stop
  task automatic push_reply(input logic [31:0] w, input int nbits,
                            input bit full);
    logic b;
    push(EV_TURN, 200);
    for (int i = 0; i < nbits; i++) begin
      b = w[31-i];
      push(EV_LOW, b ? 100 : 300);
      push(EV_HIGH, b ? 300 : 100);
    end
    if (full) begin
      push(EV_LOW, 200);
      push(EV_DONE, 0);
    end
  endtask

  task automatic got(input int k, input int v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_%s got=%0d required=no event",
               kname[k], v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v) begin
        failures++;
        $display("FAIL ev_%s got %s=%0d required %s=%0d",
                 kname[e.kind], kname[k], v, kname[e.kind], e.val);
      end
    end
  endtask

  task automatic drain(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, act, req);
    end
  endtask

  // Line must stay released and tx_active low for n cycles
  task automatic expect_quiet(input string name, input int n);
    bit bad;
    bad = 1'b0;
    repeat (n) begin
      @(negedge PCLK);
      if (bus.tx_active || fab_pin !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL %s got=line driven required=quiet", name);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int n,
                           input bit stop);
    for (int i = 7; i > 7 - n; i--) begin
      con_low = 1'b1;
      repeat (b[i] ? 100 : 300) @(negedge PCLK);
      con_low = 1'b0;
      repeat (b[i] ? 300 : 100) @(negedge PCLK);
    end
    if (stop) begin
      con_low = 1'b1;
      repeat (100) @(negedge PCLK);
      con_low = 1'b0;
    end
  endtask

  // Monitor: decodes DUT pulses and pulses into scoreboard events
  int  lcnt;
  int  hcnt;
  int  tcnt;
  bit  lo_on;
  bit  hi_on;
  bit  turn_on;

  always @(negedge PCLK) begin
    if (!PRESERN) begin
      lcnt    = 0;
      hcnt    = 0;
      tcnt    = 0;
      lo_on   = 1'b0;
      hi_on   = 1'b0;
      turn_on = 1'b0;
    end else begin
      if (bus.tx_active && fab_pin === 1'b0) begin
        if (turn_on) begin
          got(EV_TURN, tcnt);
          turn_on = 1'b0;
        end
        if (hi_on) begin
          got(EV_HIGH, hcnt);
          hi_on = 1'b0;
        end
        lcnt++;
        lo_on = 1'b1;
      end else if (lo_on && fab_pin === 1'b1) begin
        got(EV_LOW, lcnt);
        lo_on = 1'b0;
        lcnt  = 0;
        if (bus.tx_active) begin
          hi_on = 1'b1;
          hcnt  = 1;
        end
      end else if (hi_on) begin
        hcnt++;
      end
      if (turn_on) tcnt++;
      if (bus.cmd_valid) begin
        got(EV_CMD, int'(bus.cmd_byte));
        turn_on = 1'b1;
        tcnt    = 1;
      end
      if (bus.rx_error) got(EV_ERR, 0);
      if (bus.resp_done) got(EV_DONE, 0);
    end
  end

  initial begin
    int k;
    checks          = 0;
    failures        = 0;
    con_low         = 1'b0;
    PRESERN         = 1'b0;
    bus.button_data = 32'h8000_0001;
    repeat (3) @(negedge PCLK);
    #1;
    chk("rst_fab_pin", 32'(fab_pin), 32'h1);
    chk("rst_tx_active", 32'(bus.tx_active), 32'h0);
    chk("rst_cmd_valid", 32'(bus.cmd_valid), 32'h0);
    chk("rst_cmd_byte", 32'(bus.cmd_byte), 32'h0);
    chk("rst_resp_done", 32'(bus.resp_done), 32'h0);
    chk("rst_rx_error", 32'(bus.rx_error), 32'h0);
    PRESERN = 1'b1;
    repeat (10) @(negedge PCLK);

    // Poll with 8000_0001: 1, thirty 0s, 1, then stop
    push(EV_CMD, 8'h01);
    push_reply(32'h8000_0001, 32, 1'b1);
    send_bits(8'h01, 8, 1'b1);
    repeat (14000) @(negedge PCLK);
    drain("poll_8000_0001");

    // Info command: status reply only with the optional feature
    push(EV_CMD, 8'h00);
`ifdef N64_RESP_STATUS_EN
    push_reply({24'h050002, 8'h00}, 24, 1'b1);
    send_bits(8'h00, 8, 1'b1);
    repeat (10600) @(negedge PCLK);
`else
    send_bits(8'h00, 8, 1'b1);
    expect_quiet("info_no_reply", 800);
`endif
    drain("info");

    // Unknown command: decoded, never answered
    push(EV_CMD, 8'h42);
    send_bits(8'h42, 8, 1'b1);
    expect_quiet("cmd42_no_reply", 700);
    drain("cmd42");

    // Four bits then idle high: silent abort, then a normal poll
    send_bits(8'h01, 4, 1'b0);
    expect_quiet("partial_quiet", 700);
    drain("partial");
    bus.button_data = 32'h1234_5678;
    push(EV_CMD, 8'h01);
    push_reply(32'h1234_5678, 32, 1'b1);
    send_bits(8'h01, 8, 1'b1);
    repeat (14000) @(negedge PCLK);
    drain("poll_after_partial");

    // Line held low mid-byte: one rx_error, frame during recovery ignored
    push(EV_ERR, 0);
    send_bits(8'hA0, 3, 1'b0);
    con_low = 1'b1;
    repeat (600) @(negedge PCLK);
    con_low = 1'b0;
    repeat (100) @(negedge PCLK);
    send_bits(8'h42, 8, 1'b1);
    repeat (700) @(negedge PCLK);
    drain("low_hold_error");
    push(EV_CMD, 8'h42);
    send_bits(8'h42, 8, 1'b1);
    repeat (300) @(negedge PCLK);
    drain("decode_after_recovery");

    // Poll: change button_data at bit 10, reset at bit 20
    bus.button_data = 32'hA5C3_0F96;
    push(EV_CMD, 8'h01);
    push_reply(32'hA5C3_0F96, 20, 1'b0);
    send_bits(8'h01, 8, 1'b1);
    k = 0;
    while (!bus.cmd_valid && k < 200) begin
      @(negedge PCLK);
      k++;
    end
    chk("poll_cmd_seen", 32'(bus.cmd_valid), 32'h1);
    repeat (4250) @(negedge PCLK);
    bus.button_data = 32'h0000_0000;
    repeat (4000) @(negedge PCLK);
    #2;
    PRESERN = 1'b0;
    #1;
    chk("mid_rst_fab_pin", 32'(fab_pin), 32'h1);
    chk("mid_rst_tx_active", 32'(bus.tx_active), 32'h0);
    chk("mid_rst_cmd_byte", 32'(bus.cmd_byte), 32'h0);
    chk("mid_rst_resp_done", 32'(bus.resp_done), 32'h0);
    chk("mid_rst_rx_error", 32'(bus.rx_error), 32'h0);
    drain("poll_before_reset");
    repeat (5) @(negedge PCLK);
    #2;
    PRESERN = 1'b1;
    repeat (10) @(negedge PCLK);
    push(EV_CMD, 8'h42);
    send_bits(8'h42, 8, 1'b1);
    expect_quiet("post_reset_quiet", 300);
    drain("post_reset_decode");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/n64_controller_responder.md
Name: n64_controller_responder

Overview:
- Device-side end of the N64 single-wire joybus link. It emulates a controller toward a console or toward our own host-side serial poller in loopback.
- Receives a command byte on the open-drain fab_pin and replies with latched button data (poll) or status bytes.
- Sits behind an APB register block that supplies button_data. It is used for bench loopback of the poller and for console-facing builds.

Parameters:
- CYCLES_PER_US, 100, PCLK cycles per microsecond; all protocol timing derives from it.
- TURNAROUND_US, 2, idle-high time after the console stop bit before the response starts.
- TIMEOUT_US, 5, max low or high time inside a frame before abort.

Ports:
- PCLK  in  1  system clock.
- PRESERN  in  1  asynchronous active-low reset.
- fab_pin  inout  1  joybus line; driven 0 or Z only, never driven 1.
- button_data  in  32  current controller word, MSB transmitted first.
- tx_active  out  1  high while the block drives or owns the line (turnaround through response stop bit).
- cmd_valid  out  1  one-cycle pulse when a full command byte plus stop bit is received.
- cmd_byte  out  8  last received command; valid from the cmd_valid pulse until the next one.
- resp_done  out  1  one-cycle pulse after the response stop bit is released.
- rx_error  out  1  one-cycle pulse on timeout or malformed frame.

Behaviour:
- Reset values: fab_pin=Z, tx_active=0, cmd_valid=0, cmd_byte=8'h00, resp_done=0, rx_error=0, FSM=IDLE, all counters 0.
- Reset is asynchronous. Asserting reset mid-response releases the line to Z immediately.
- Input path: fab_pin passes through a 2-flop synchronizer. All edge detection uses the synchronized value, so there are 2 cycles of latency.
- IDLE -> RX_LOW on a synchronized falling edge.
- RX_LOW counts low cycles. On the rising edge:
  - low count <= 2*CYCLES_PER_US decodes as bit 1; otherwise bit 0.
  - Bits shift in MSB first; go to RX_HIGH.
  - Low count > TIMEOUT_US*CYCLES_PER_US -> rx_error, go to WAIT_IDLE.
- RX_HIGH: a falling edge starts the next bit (RX_LOW), or the stop bit (RX_STOP) once 8 bits are held. High for > TIMEOUT_US mid-byte aborts silently to IDLE: no cmd_valid, no rx_error.
- RX_STOP: the stop low must end within TIMEOUT_US; then pulse cmd_valid and latch cmd_byte.
  - cmd 8'h01 -> snapshot button_data into the 32-bit tx shift register on that same cycle; go to TURNAROUND with length 32.
  - cmd 8'h00 or 8'hFF -> load 24'h050002 (optional feature only); go to TURNAROUND with length 24.
  - Any other cmd -> IDLE, no drive.
- TURNAROUND: wait TURNAROUND_US*CYCLES_PER_US cycles. tx_active rises on entry.
- TX_LOW / TX_HIGH, per bit, MSB first:
  - bit 0: 3us low, 1us high.
  - bit 1: 1us low, 3us high.
- TX_STOP: drive low 2us, release, pulse resp_done, clear tx_active, go to WAIT_IDLE.
- The line input is ignored while tx_active=1. Changes on button_data during TX do not affect the word being sent.
- WAIT_IDLE: return to IDLE after the line has been continuously high for TIMEOUT_US. A console holding the line low keeps the block here.
- A falling edge arriving while in WAIT_IDLE is not decoded.

Optional Feature:
- Macro N64_RESP_STATUS_EN.
- Defined: commands 8'h00 (info) and 8'hFF (reset) get the 24-bit status reply 24'h050002.
- Undefined: those commands still pulse cmd_valid, but the block returns to IDLE with no reply. Only 8'h01 is answered.

Decomposition:
- Shared package n64_pkg:
  - command constants CMD_INFO=8'h00, CMD_POLL=8'h01, CMD_RESET=8'hFF;
  - STATUS_WORD=24'h050002;
  - FSM state enum;
  - bit-timing multipliers (1, 2, 3 us).
- One natural sub-module, n64_pulse_timer: loadable down-counter with a done flag. It is shared by the RX timeout, turnaround and TX bit phases.

Test Plan (CYCLES_PER_US=100):
- Console sends 0x01 plus stop, button_data=32'h8000_0001:
  - cmd_valid pulses with cmd_byte=8'h01;
  - after 200 cycles fab_pin shows the first bit as 100 low / 300 high;
  - the next 30 bits are 300/100 each; the last bit is 100/300;
  - then 200 low, then resp_done pulses.
- Console sends 0x00, with and without N64_RESP_STATUS_EN:
  - with the macro: reply bits 0000_0101_0000_0000_0000_0010, then stop bit;
  - without the macro: cmd_valid pulses and fab_pin stays Z.
- Console sends 0x42: cmd_valid pulses with cmd_byte=8'h42; fab_pin stays Z; tx_active stays 0.
- Console sends 4 bits, then holds the line high 600 cycles: no cmd_valid, no rx_error, FSM returns to IDLE. A following valid 0x01 is answered normally.
- Console holds the line low 600 cycles mid-byte: rx_error pulses once. No decode occurs until the line has been high 500 cycles.
- Timing and reset during a poll response:
  - change button_data at bit 10 -> the originally latched word is sent;
  - assert PRESERN=0 at bit 20 -> fab_pin goes Z the same cycle, all outputs reach their reset values, FSM=IDLE.
